button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
// - Front-end for the piano-key push buttons. Takes N_BTN raw asynchronous buttons and
//   produces clean levels for the long/short press classifier stage downstream.
// - Per channel: 2-flop synchronizer, debounce on a shared sample tick, then one-cycle
//   rise/fall pulses.
// - Exports the sample tick so downstream press-duration counters can count in ticks.
// PARAMETERS
// - N_BTN         4       number of independent button channels (>=1)
// - CLK_DIV       100000  clk cycles per sample tick (>=1; 1 = tick every cycle)
// - STABLE_TICKS  10      consecutive differing samples required to accept a new level (>=1)
// PORTS
// - clk       in   1      system clock
// - rst_n     in   1      asynchronous, active-low reset
// - btn_raw   in   N_BTN  raw button inputs, asynchronous to clk, active-high
// - tick      out  1      one-clk strobe, once every CLK_DIV cycles
// - btn_lv    out  N_BTN  debounced button level
// - btn_rise  out  N_BTN  one-clk pulse when btn_lv goes 0->1
// - btn_fall  out  N_BTN  one-clk pulse when btn_lv goes 1->0
// BEHAVIOUR
// - Reset: all outputs, synchronizer flops, the prescaler and the per-channel counters go to 0.
//   Reset asserted mid-operation aborts any pending debounce. No pulse is generated on reset exit.
// - Synchronizer: sync[i] = btn_raw[i] delayed by 2 clk flops. Only sync is sampled.
// - Prescaler:
//   - div_cnt has width $clog2(CLK_DIV) (min 1). It counts 0..CLK_DIV-1 and wraps to 0.
//   - tick is registered and is 1 in the cycle after div_cnt==CLK_DIV-1.
//   - After reset release, the first tick is high on clk edge CLK_DIV+1; after that, every CLK_DIV cycles.
//   - With CLK_DIV=1, tick stays high continuously from the 2nd edge onward.
// - Debounce, per channel i, evaluated only in cycles where tick==1:
//   - sync[i]==btn_lv[i]: cnt[i]<=0 (bounce discards progress).
//   - sync[i]!=btn_lv[i] and cnt[i]==STABLE_TICKS-1: btn_lv[i]<=sync[i], cnt[i]<=0, and the
//     matching rise/fall flop is set.
//   - Otherwise: cnt[i]<=cnt[i]+1.
//   - cnt[i] width is $clog2(STABLE_TICKS) (min 1). It never exceeds STABLE_TICKS-1.
//   - In cycles where tick==0, cnt and btn_lv hold.
// - Pulses: btn_rise/btn_fall are registered and high for exactly one clk, in the same cycle
//   btn_lv changes. A rise and a fall never occur together on one channel. Different
//   channels are independent and may pulse in the same cycle.
// - Latency (raw edge to btn_lv change): 2 clk + time to the next tick + (STABLE_TICKS-1)*CLK_DIV
//   + 1 clk. The worst case adds up to CLK_DIV further cycles of tick phase.
// - Minimum accepted pulse width: STABLE_TICKS ticks. Shorter glitches never reach btn_lv.
// - Fully synchronous after the input synchronizer. No combinational path from btn_raw to any output.
// TESTING (bench params N_BTN=2, CLK_DIV=4, STABLE_TICKS=3)
// - Reset: hold rst_n=0 with btn_raw=2'b11 -> tick=btn_lv=btn_rise=btn_fall=0. Release -> tick
//   first high on clk edge 5, then every 4 cycles.
// - Clean press: btn_raw[0]=1 held -> btn_lv[0] rises exactly at the 3rd tick after sync[0]=1,
//   btn_rise[0]=1 for 1 clk. btn_lv[1], btn_rise[1] and btn_fall stay 0.
// - Bounce: btn_raw[0] high for 2 ticks, low for 1 tick, then high -> no btn_rise after the
//   first 2 ticks. btn_lv[0] rises only after 3 further consecutive high ticks.
// - Release: from btn_lv[0]=1, drop btn_raw[0] -> btn_fall[0] 1-clk pulse on the 3rd low tick,
//   btn_lv[0]=0. A 1-tick low glitch causes no fall.
// - Simultaneous: both channels rise on the same clk -> btn_rise=2'b11 for one clk,
//   btn_lv=2'b11.
// - Reset mid-count: assert rst_n=0 after 2 high ticks, release with btn_raw still high -> all
//   outputs 0. A full 3 fresh ticks are needed before btn_rise. No spurious pulse at release.

Source files
------------

// File: rtl/button_conditioner.sv
// Push-button front-end: 2-flop synchronizer, tick-paced debounce and
// one-clock rise/fall pulses per channel, plus the shared sample tick.
module button_conditioner #(
    parameter int N_BTN        = 4,
    parameter int CLK_DIV      = 100000,
    parameter int STABLE_TICKS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic             tick,
    output logic [N_BTN-1:0] btn_lv,
    output logic [N_BTN-1:0] btn_rise,
    output logic [N_BTN-1:0] btn_fall
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;

    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_TICKS - 1);

    logic [N_BTN-1:0]         sync1_q, sync1_d;
    logic [N_BTN-1:0]         sync2_q, sync2_d;
    logic [DW-1:0]            div_cnt_q, div_cnt_d;
    logic                     tick_q, tick_d;
    logic [N_BTN-1:0][CW-1:0] cnt_q, cnt_d;
    logic [N_BTN-1:0]         lv_q, lv_d;
    logic [N_BTN-1:0]         rise_q, rise_d;
    logic [N_BTN-1:0]         fall_q, fall_d;

    // Two-stage synchronizer; only the second stage feeds the debouncer.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
    end

    // Prescaler: wraps every CLK_DIV cycles, tick registered one cycle later.
    always_comb begin
        tick_d = (div_cnt_q == DIV_MAX);
        if (div_cnt_q == DIV_MAX) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + DW'(1);
        end
    end

    // Debounce: a new level needs STABLE_TICKS consecutive differing samples.
    always_comb begin
        cnt_d  = cnt_q;
        lv_d   = lv_q;
        rise_d = '0;
        fall_d = '0;
        if (tick_q) begin
            for (int i = 0; i < N_BTN; i++) begin
                if (sync2_q[i] == lv_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    cnt_d[i]  = '0;
                    lv_d[i]   = sync2_q[i];
                    rise_d[i] = sync2_q[i];
                    fall_d[i] = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // State registers; reset clears everything so no pulse appears on exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
            cnt_q     <= '0;
            lv_q      <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
            cnt_q     <= cnt_d;
            lv_q      <= lv_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
        end
    end

    assign tick     = tick_q;
    assign btn_lv   = lv_q;
    assign btn_rise = rise_q;
    assign btn_fall = fall_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (N_BTN=2, CLK_DIV=4, STABLE_TICKS=3).
// Cycle numbers count clk edges since the latest reset release.
module tb_button_conditioner;

    logic       clk;
    logic       rst_n;
    logic [1:0] btn_raw;
    logic       tick;
    logic [1:0] btn_lv;
    logic [1:0] btn_rise;
    logic [1:0] btn_fall;

    int n_chk;
    int n_err;
    int cyc;

    button_conditioner #(
        .N_BTN       (2),
        .CLK_DIV     (4),
        .STABLE_TICKS(3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_raw),
        .tick    (tick),
        .btn_lv  (btn_lv),
        .btn_rise(btn_rise),
        .btn_fall(btn_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h exp %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    task automatic chk_out(input string tag, input logic [1:0] lv,
                           input logic [1:0] rise, input logic [1:0] fall);
        chk({tag, ".lv"}, 32'(btn_lv), 32'(lv));
        chk({tag, ".rise"}, 32'(btn_rise), 32'(rise));
        chk({tag, ".fall"}, 32'(btn_fall), 32'(fall));
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        cyc     = 0;
        rst_n   = 1'b0;
        btn_raw = 2'b11;

        // Reset state with inputs held high
        repeat (3) step();
        chk("rst.tick", 32'(tick), 32'd0);
        chk_out("rst", 2'b00, 2'b00, 2'b00);

        rst_n   = 1'b1;
        btn_raw = 2'b00;
        cyc     = 0;

        // Tick: high in the cycle after edges 4, 8, 12
        for (int n = 1; n <= 12; n++) begin
            step();
            chk("tick", 32'(tick), 32'((cyc % 4) == 0));
        end
        chk_out("idle", 2'b00, 2'b00, 2'b00);

        // Clean press on ch0: updates at 17, 21, 25
        btn_raw = 2'b01;
        goto(21);
        chk_out("press.21", 2'b00, 2'b00, 2'b00);
        goto(24);
        chk_out("press.24", 2'b00, 2'b00, 2'b00);
        step();
        chk_out("press.25", 2'b01, 2'b01, 2'b00);
        step();
        chk_out("press.26", 2'b01, 2'b00, 2'b00);

        // Release with a 1-tick low glitch first
        btn_raw = 2'b00;
        goto(30);
        btn_raw = 2'b01;
        goto(33);
        chk_out("glitch.33", 2'b01, 2'b00, 2'b00);
        goto(34);
        btn_raw = 2'b00;
        goto(41);
        chk_out("rel.41", 2'b01, 2'b00, 2'b00);
        goto(44);
        chk_out("rel.44", 2'b01, 2'b00, 2'b00);
        step();
        chk_out("rel.45", 2'b00, 2'b00, 2'b01);
        step();
        chk_out("rel.46", 2'b00, 2'b00, 2'b00);

        // Bounce on press: high 2 ticks, low 1 tick, then high
        btn_raw = 2'b01;
        goto(54);
        btn_raw = 2'b00;
        goto(57);
        chk_out("bnc.57", 2'b00, 2'b00, 2'b00);
        goto(58);
        btn_raw = 2'b01;
        goto(65);
        chk_out("bnc.65", 2'b00, 2'b00, 2'b00);
        goto(68);
        chk_out("bnc.68", 2'b00, 2'b00, 2'b00);
        step();
        chk_out("bnc.69", 2'b01, 2'b01, 2'b00);
        step();
        chk_out("bnc.70", 2'b01, 2'b00, 2'b00);

        // Drop ch0, then raise both channels together
        btn_raw = 2'b00;
        goto(81);
        chk_out("drop.81", 2'b00, 2'b00, 2'b01);
        step();
        btn_raw = 2'b11;
        goto(92);
        chk_out("sim.92", 2'b00, 2'b00, 2'b00);
        step();
        chk_out("sim.93", 2'b11, 2'b11, 2'b00);
        step();
        chk_out("sim.94", 2'b11, 2'b00, 2'b00);

        // Both fall together
        btn_raw = 2'b00;
        goto(104);
        chk_out("fall2.104", 2'b11, 2'b00, 2'b00);
        step();
        chk_out("fall2.105", 2'b00, 2'b00, 2'b11);
        step();

        // Reset during a pending debounce (2 high ticks at 109, 113)
        btn_raw = 2'b01;
        goto(114);
        rst_n = 1'b0;
        #1;
        chk("mid.tick", 32'(tick), 32'd0);
        chk_out("mid.rst", 2'b00, 2'b00, 2'b00);
        repeat (3) step();
        rst_n = 1'b1;
        cyc   = 0;
        step();
        chk_out("mid.1", 2'b00, 2'b00, 2'b00);
        goto(9);
        chk_out("mid.9", 2'b00, 2'b00, 2'b00);
        goto(12);
        chk_out("mid.12", 2'b00, 2'b00, 2'b00);
        step();
        chk_out("mid.13", 2'b01, 2'b01, 2'b00);
        step();
        chk_out("mid.14", 2'b01, 2'b00, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
